tnn_feature_loader: RTL
=======================

# tnn_feature_loader

Upstream front end for the 2-bit, 7-input approximate TNN classifier cores in the breast-cancer library. It accepts raw 8-bit feature samples one per beat over a valid/ready stream and quantizes each one to 2 bits against programmable per-feature thresholds. It assembles the 7 quantized features into one 14-bit vector and holds it on a registered valid/ready output until the downstream neuron wrapper takes it. It also detects framing errors and resynchronises on `s_last`.

## Interface
- `N_FEAT`, 7, features per frame (index 0..N_FEAT-1)
- `RAW_W`, 8, raw feature width
- `Q_W`, 2, quantized feature width (fixed at 2; 3 thresholds per feature)

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `s_valid`  in  1  raw beat valid
- `s_ready`  out  1  loader accepts beat
- `s_data`  in  RAW_W  raw feature value, unsigned
- `s_last`  in  1  marks final feature of a frame
- `thr_we`  in  1  threshold write strobe
- `thr_addr`  in  5  feature*3 + level (0..20)
- `thr_wdata`  in  RAW_W  threshold value
- `m_valid`  out  1  vector valid
- `m_ready`  in  1  downstream accepts vector
- `m_vec`  out  N_FEAT*Q_W  quantized vector; feature i at bits [2i+1:2i] (feature 0 drives input_a, feature 6 drives input_g)
- `frm_err`  out  1  one-cycle pulse on framing error
- `err_cnt`  out  8  saturating framing-error count

## Operation
- A beat transfers when `s_valid && s_ready`. Quantization: q = (raw>=T[i][0]) + (raw>=T[i][1]) + (raw>=T[i][2]), computed combinationally from the beat and the current feature index i. The result is a count, so unordered thresholds are legal and never produce a value above 3.
- Threshold file: 21 × RAW_W registers. Reset values per feature are 0x40, 0x80, 0xC0. Writes with `thr_addr` > 20 are ignored. A write in the same cycle as a beat: the beat uses the old value.
- FSM states:
  - COLLECT: index 0..6, beats written into the assembly register.
  - HOLD: assembly complete, output register occupied.
  - DROP: discarding beats after an error.
- COLLECT, beat with index<6 and `s_last`=1: pulse `frm_err`, increment `err_cnt` (saturates at 255), discard the partial frame, set index=0, stay in COLLECT.
- COLLECT, beat with index<6 and `s_last`=0: store the quantized feature, index+1.
- COLLECT, beat with index=6 and `s_last`=0: pulse `frm_err`, increment `err_cnt`, discard the frame, go to DROP.
- COLLECT, beat with index=6 and `s_last`=1: the frame is complete.
  - If the output register is free, or freed in this cycle by `m_valid && m_ready`, load the vector into it, set index=0, stay in COLLECT.
  - Otherwise keep the vector in the assembly register and go to HOLD.
- HOLD: `s_ready`=0. When the output is accepted, move the assembly vector to the output register in that cycle, set index=0, go to COLLECT.
- DROP: `s_ready`=1. Consume beats until a beat with `s_last`=1 (inclusive), then set index=0 and go to COLLECT. No further errors are counted while in DROP.
- Output register: `m_vec` is stable while `m_valid`=1 and `m_ready`=0. `m_valid` clears on acceptance unless a new vector loads in the same cycle.

## Timing
- Reset values:
  - `s_ready`=1, `m_valid`=0, `m_vec`=0, `frm_err`=0, `err_cnt`=0.
  - FSM in COLLECT, index=0, thresholds at their default values.
- Latency: `m_valid` rises in the cycle after the accepted `s_last` beat.
- Throughput: 1 beat/cycle while the output drains. Back-to-back frames with `m_ready`=1 constant sustain one vector per 7 cycles with no bubbles.
- `s_ready` is 0 only in HOLD. In COLLECT it is 1, including during the last beat; buffering is provided by the assembly register.
- Reset asserted mid-frame or mid-HOLD: all state clears immediately. A partial frame is lost and no error is counted.
- `frm_err` is asserted in the cycle after the offending beat, for exactly 1 cycle.

## Structure
- Shared package `tnn_pkg`:
  - constants `N_FEAT`, `Q_W`, `RAW_W`, `THR_PER_FEAT`=3
  - FSM state enum (COLLECT, HOLD, DROP)
  - threshold reset defaults
- One sub-module, `tnn_quant2`: purely combinational. Ports are raw value and 3 thresholds; output is the 2-bit count. Instantiated once and muxed by index.
- The top level contains the FSM, index counter, threshold file, assembly register, output register and error counter.

## Test plan
- Default thresholds, `m_ready`=1, frame 0x00,0x3F,0x40,0x7F,0x80,0xC0,0xFF with `s_last` on beat 7 -> `m_vec`=14'b11_11_10_01_01_00_00 one cycle after beat 7, with `m_valid` high for 1 cycle.
- Write T[3]={0x10,0x10,0x10}, then send a frame with feature 3 = 0x10 and feature 3 = 0x0F -> q3=3 and q3=0 respectively. A write to addr 21 leaves all thresholds unchanged.
- Hold `m_ready`=0 and send 2 full frames -> the first vector is held stable. `s_ready` drops after the 14th beat. Raising `m_ready` presents the second vector the next cycle and no beats are lost.
- `s_last` on beat 4 -> `frm_err` pulses and `err_cnt`=1. The next 7-beat frame is output correctly.
- No `s_last` on beat 7, then 3 extra beats with `s_last` on the third -> `err_cnt`=1 with no vector output. The following frame is correct.
- Assert `rst_n`=0 after beat 5 -> outputs return to reset values. The next full frame is output correctly.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared constants, FSM encoding and threshold reset defaults for the TNN feature loader.
package tnn_pkg;

    localparam int N_FEAT       = 7;
    localparam int Q_W          = 2;
    localparam int RAW_W        = 8;
    localparam int THR_PER_FEAT = 3;
    localparam int N_THR        = N_FEAT * THR_PER_FEAT;
    localparam int VEC_W        = N_FEAT * Q_W;
    localparam int IDX_W        = 3;
    localparam int THR_AW       = 5;
    localparam int ERR_W        = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DROP    = 2'd2
    } state_t;

    function automatic logic [RAW_W-1:0] thr_default(input int lvl);
        case (lvl)
            0:       thr_default = 8'h40;
            1:       thr_default = 8'h80;
            default: thr_default = 8'hC0;
        endcase
    endfunction

endpackage

// File: rtl/tnn_feature_loader_if.sv
// Raw-beat stream, threshold write port and quantized-vector stream of the feature loader.
interface tnn_feature_loader_if;

    logic                              s_valid;
    logic                              s_ready;
    logic [tnn_pkg::RAW_W-1:0]         s_data;
    logic                              s_last;
    logic                              thr_we;
    logic [tnn_pkg::THR_AW-1:0]        thr_addr;
    logic [tnn_pkg::RAW_W-1:0]         thr_wdata;
    logic                              m_valid;
    logic                              m_ready;
    logic [tnn_pkg::VEC_W-1:0]         m_vec;
    logic                              frm_err;
    logic [tnn_pkg::ERR_W-1:0]         err_cnt;

    modport master (
        output s_valid, s_data, s_last, thr_we, thr_addr, thr_wdata, m_ready,
        input  s_ready, m_valid, m_vec, frm_err, err_cnt
    );

    modport slave (
        input  s_valid, s_data, s_last, thr_we, thr_addr, thr_wdata, m_ready,
        output s_ready, m_valid, m_vec, frm_err, err_cnt
    );

endinterface

// File: rtl/tnn_quant2.sv
// Combinational 2-bit quantizer: counts how many of three thresholds the raw value reaches.
module tnn_quant2
    import tnn_pkg::*;
(
    input  logic [RAW_W-1:0] raw,
    input  logic [RAW_W-1:0] thr0,
    input  logic [RAW_W-1:0] thr1,
    input  logic [RAW_W-1:0] thr2,
    output logic [Q_W-1:0]   q
);

    logic [Q_W-1:0] ge0, ge1, ge2;

    // A count rather than a priority encode, so unordered thresholds still saturate at 3.
    assign ge0 = {1'b0, raw >= thr0};
    assign ge1 = {1'b0, raw >= thr1};
    assign ge2 = {1'b0, raw >= thr2};
    assign q   = ge0 + ge1 + ge2;

endmodule

// File: rtl/tnn_feature_loader.sv
// Quantizes 7 raw beats into a 14-bit vector; m_valid rises the cycle after the last beat.
// s_ready drops only in HOLD, when both the assembly and output registers are full.
module tnn_feature_loader
    import tnn_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    tnn_feature_loader_if.slave bus
);

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [RAW_W-1:0]     thr [N_THR];
    logic [VEC_W-1:0]     asm_vec;
    logic [VEC_W-1:0]     out_vec;
    logic                 out_vld;
    logic                 frm_err_q;
    logic [ERR_W-1:0]     err_cnt_q;

    logic                 beat;
    logic                 last_idx;
    logic                 out_free;
    logic [THR_AW-1:0]    thr_base;
    logic [Q_W-1:0]       q;

    logic                 s_ready_c;
    logic                 asm_wr;
    logic                 out_ld_beat;
    logic                 out_ld_hold;
    logic                 err_evt;
    logic                 idx_clr;
    logic                 idx_inc;

    assign beat     = bus.s_valid && s_ready_c;
    assign last_idx = (idx == IDX_W'(N_FEAT - 1));
    assign out_free = !out_vld || bus.m_ready;
    assign thr_base = {2'b00, idx} * 5'd3;

    tnn_quant2 u_quant (
        .raw  (bus.s_data),
        .thr0 (thr[thr_base]),
        .thr1 (thr[thr_base + 5'd1]),
        .thr2 (thr[thr_base + 5'd2]),
        .q    (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (beat && last_idx) begin
                    if (!bus.s_last)    state_nxt = DROP;
                    else if (!out_free) state_nxt = HOLD;
                end
            end
            HOLD:    if (bus.m_ready)          state_nxt = COLLECT;
            DROP:    if (beat && bus.s_last)   state_nxt = COLLECT;
            default:                           state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        s_ready_c   = 1'b1;
        asm_wr      = 1'b0;
        out_ld_beat = 1'b0;
        out_ld_hold = 1'b0;
        err_evt     = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        case (state)
            COLLECT: begin
                if (beat) begin
                    if (!last_idx) begin
                        if (bus.s_last) begin
                            err_evt = 1'b1;
                            idx_clr = 1'b1;
                        end else begin
                            asm_wr  = 1'b1;
                            idx_inc = 1'b1;
                        end
                    end else if (!bus.s_last) begin
                        err_evt = 1'b1;
                        idx_clr = 1'b1;
                    end else if (out_free) begin
                        out_ld_beat = 1'b1;
                        idx_clr     = 1'b1;
                    end else begin
                        // Park the final feature; the whole vector moves out from HOLD.
                        asm_wr = 1'b1;
                    end
                end
            end
            HOLD: begin
                s_ready_c = 1'b0;
                if (bus.m_ready) begin
                    out_ld_hold = 1'b1;
                    idx_clr     = 1'b1;
                end
            end
            DROP: begin
                if (beat && bus.s_last) idx_clr = 1'b1;
            end
            default: begin
                idx_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            asm_vec <= '0;
        end else begin
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + IDX_W'(1);
            if (asm_wr)       asm_vec[{idx, 1'b0} +: Q_W] <= q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vec <= '0;
            out_vld <= 1'b0;
        end else if (out_ld_beat) begin
            out_vec <= {q, asm_vec[VEC_W-Q_W-1:0]};
            out_vld <= 1'b1;
        end else if (out_ld_hold) begin
            out_vec <= asm_vec;
            out_vld <= 1'b1;
        end else if (bus.m_ready) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            frm_err_q <= err_evt;
            if (err_evt && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    // The quantizer reads the registered file, so a write coinciding with a beat lands afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < N_THR; a++) thr[a] <= thr_default(a % THR_PER_FEAT);
        end else if (bus.thr_we && (bus.thr_addr < THR_AW'(N_THR))) begin
            thr[bus.thr_addr] <= bus.thr_wdata;
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = out_vld;
    assign bus.m_vec   = out_vec;
    assign bus.frm_err = frm_err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule
